// File: rtl/xvc_pkg.sv
// Shared constants and types for the multi-channel XVC AXI-Lite master.
package xvc_pkg;

  localparam logic [1:0] OP_IDLE = 2'b00;
  localparam logic [1:0] OP_RD   = 2'b01;
  localparam logic [1:0] OP_WR   = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [3:0] AXCACHE = 4'b0011;
  localparam logic [2:0] AXPROT  = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_A,
    ST_RD_D,
    ST_WR_AW_W,
    ST_WR_B,
    ST_DONE
  } state_t;

  function automatic logic is_req(input logic [1:0] op);
    return (op == OP_RD) || (op == OP_WR);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = 2
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic [N-1:0] grant,
  output logic [W-1:0] idx,
  output logic         any
);

  always_comb begin
    int c;
    c     = 0;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int k = 0; k < N; k++) begin
      c = int'(ptr) + k;
      if (c >= N) c = c - N;
      if (!any && req[c]) begin
        any      = 1'b1;
        grant[c] = 1'b1;
        idx      = W'(c);
      end
    end
  end

endmodule

// File: rtl/xvc_axil_mux_master.sv
// NUM_CH XVC command engines sharing one AXI-Lite master port, round-robin
// arbitrated, each channel mapped to its own address window, with a timeout.
module xvc_axil_mux_master
  import xvc_pkg::*;
#(
  parameter int NUM_CH    = 4,
  parameter int CH_ADDR_W = 12,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 1024,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int AXI_AW   = CH_W + CH_ADDR_W
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_CH*CH_ADDR_W-1:0] usr_addr,
  input  logic [NUM_CH*DATA_W-1:0]    usr_wdata,
  input  logic [2*NUM_CH-1:0]         usr_opcode,
  output logic [DATA_W-1:0]           usr_rdata,
  output logic [NUM_CH-1:0]           usr_rvalid,
  output logic [NUM_CH-1:0]           usr_wdone,
  output logic [NUM_CH-1:0]           usr_err,
  output logic [NUM_CH-1:0]           usr_busy,
  output logic [AXI_AW-1:0]           m_axi_awaddr,
  output logic [2:0]                  m_axi_awprot,
  output logic [3:0]                  m_axi_awcache,
  output logic                        m_axi_awvalid,
  input  logic                        m_axi_awready,
  output logic [DATA_W-1:0]           m_axi_wdata,
  output logic [DATA_W/8-1:0]         m_axi_wstrb,
  output logic                        m_axi_wvalid,
  input  logic                        m_axi_wready,
  input  logic [1:0]                  m_axi_bresp,
  input  logic                        m_axi_bvalid,
  output logic                        m_axi_bready,
  output logic [AXI_AW-1:0]           m_axi_araddr,
  output logic [2:0]                  m_axi_arprot,
  output logic [3:0]                  m_axi_arcache,
  output logic                        m_axi_arvalid,
  input  logic                        m_axi_arready,
  input  logic [DATA_W-1:0]           m_axi_rdata,
  input  logic [1:0]                  m_axi_rresp,
  input  logic                        m_axi_rvalid,
  output logic                        m_axi_rready
);

  localparam int TO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t                            state_reg;
  logic [CH_W-1:0]                   ptr_reg;
  logic [CH_W-1:0]                   cur_ch_reg;
  logic                              cur_wr_reg;
  logic [TO_W-1:0]                   timer_reg;
  logic [AXI_AW-1:0]                 awaddr_reg, araddr_reg;
  logic [DATA_W-1:0]                 wdata_reg, rdata_reg;
  logic                              awvalid_reg, wvalid_reg, arvalid_reg;
  logic                              rready_reg, bready_reg;
  logic [NUM_CH-1:0]                 rvalid_reg, wdone_reg, err_reg;

  logic [NUM_CH-1:0]                 pending, wr_vec, arb_grant;
  logic [NUM_CH-1:0][CH_ADDR_W-1:0]  addr_all;
  logic [NUM_CH-1:0][DATA_W-1:0]     wdata_all;
  logic [CH_W-1:0]                   arb_idx;
  logic                              arb_any, sel_wr;
  logic                              waiting, timed_out, abort;

  // Per-channel request latches; pending stays set through DONE so a new
  // opcode arriving in that cycle is not taken.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic                 pending_reg;
    logic [1:0]           op_reg;
    logic [CH_ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0]    wd_reg;
    logic [1:0]           opc;
    logic                 done_here;

    assign opc       = usr_opcode[2*gi +: 2];
    assign done_here = (state_reg == ST_DONE) && (cur_ch_reg == CH_W'(gi));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        pending_reg <= 1'b0;
        op_reg      <= OP_IDLE;
        addr_reg    <= '0;
        wd_reg      <= '0;
      end else if (pending_reg) begin
        if (done_here) pending_reg <= 1'b0;
      end else if (is_req(opc)) begin
        pending_reg <= 1'b1;
        op_reg      <= opc;
        addr_reg    <= usr_addr[gi*CH_ADDR_W +: CH_ADDR_W];
        wd_reg      <= usr_wdata[gi*DATA_W +: DATA_W];
      end
    end

    assign pending[gi]   = pending_reg;
    assign wr_vec[gi]    = (op_reg == OP_WR);
    assign addr_all[gi]  = addr_reg;
    assign wdata_all[gi] = wd_reg;
    assign usr_busy[gi]  = pending_reg && !done_here;
  end

  rr_arbiter #(.N(NUM_CH), .W(CH_W)) u_arb (
    .req   (pending & {NUM_CH{state_reg == ST_IDLE}}),
    .ptr   (ptr_reg),
    .grant (arb_grant),
    .idx   (arb_idx),
    .any   (arb_any)
  );

  assign sel_wr    = |(arb_grant & wr_vec);
  assign waiting   = (state_reg == ST_RD_A) || (state_reg == ST_RD_D) ||
                     (state_reg == ST_WR_AW_W) || (state_reg == ST_WR_B);
  assign timed_out = (TIMEOUT > 0) && (timer_reg == TO_W'(TIMEOUT - 1));
  // A completing beat in the final cycle wins over the timeout.
  assign abort     = timed_out && waiting &&
                     !((state_reg == ST_RD_D) && m_axi_rvalid) &&
                     !((state_reg == ST_WR_B) && m_axi_bvalid);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      ptr_reg     <= '0;
      cur_ch_reg  <= '0;
      cur_wr_reg  <= 1'b0;
      timer_reg   <= '0;
      awaddr_reg  <= '0;
      araddr_reg  <= '0;
      wdata_reg   <= '0;
      rdata_reg   <= '0;
      awvalid_reg <= 1'b0;
      wvalid_reg  <= 1'b0;
      arvalid_reg <= 1'b0;
      rready_reg  <= 1'b1;
      bready_reg  <= 1'b1;
      rvalid_reg  <= '0;
      wdone_reg   <= '0;
      err_reg     <= '0;
    end else begin
      if (state_reg != ST_IDLE) timer_reg <= timer_reg + 1'b1;
      case (state_reg)
        ST_IDLE: begin
          timer_reg <= '0;
          if (arb_any) begin
            cur_ch_reg <= arb_idx;
            cur_wr_reg <= sel_wr;
            ptr_reg    <= (arb_idx == CH_W'(NUM_CH - 1)) ? '0 : arb_idx + 1'b1;
            rready_reg <= 1'b0;
            bready_reg <= 1'b0;
            if (sel_wr) begin
              awaddr_reg  <= {arb_idx, addr_all[arb_idx]};
              wdata_reg   <= wdata_all[arb_idx];
              awvalid_reg <= 1'b1;
              wvalid_reg  <= 1'b1;
              state_reg   <= ST_WR_AW_W;
            end else begin
              araddr_reg  <= {arb_idx, addr_all[arb_idx]};
              arvalid_reg <= 1'b1;
              state_reg   <= ST_RD_A;
            end
          end
        end
        ST_RD_A: begin
          if (m_axi_arready) begin
            arvalid_reg <= 1'b0;
            rready_reg  <= 1'b1;
            state_reg   <= ST_RD_D;
          end
        end
        ST_RD_D: begin
          if (m_axi_rvalid) begin
            rdata_reg              <= m_axi_rdata;
            rvalid_reg[cur_ch_reg] <= 1'b1;
            err_reg[cur_ch_reg]    <= (m_axi_rresp != RESP_OKAY);
            rready_reg             <= 1'b0;
            state_reg              <= ST_DONE;
          end
        end
        ST_WR_AW_W: begin
          if (m_axi_awready) awvalid_reg <= 1'b0;
          if (m_axi_wready)  wvalid_reg  <= 1'b0;
          if ((!awvalid_reg || m_axi_awready) && (!wvalid_reg || m_axi_wready)) begin
            bready_reg <= 1'b1;
            state_reg  <= ST_WR_B;
          end
        end
        ST_WR_B: begin
          if (m_axi_bvalid) begin
            wdone_reg[cur_ch_reg] <= 1'b1;
            err_reg[cur_ch_reg]   <= (m_axi_bresp != RESP_OKAY);
            bready_reg            <= 1'b0;
            state_reg             <= ST_DONE;
          end
        end
        ST_DONE: begin
          rvalid_reg <= '0;
          wdone_reg  <= '0;
          err_reg    <= '0;
          rready_reg <= 1'b1;
          bready_reg <= 1'b1;
          state_reg  <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase

      if (abort) begin
        arvalid_reg         <= 1'b0;
        awvalid_reg         <= 1'b0;
        wvalid_reg          <= 1'b0;
        rready_reg          <= 1'b0;
        bready_reg          <= 1'b0;
        err_reg[cur_ch_reg] <= 1'b1;
        if (cur_wr_reg) begin
          wdone_reg[cur_ch_reg] <= 1'b1;
        end else begin
          rvalid_reg[cur_ch_reg] <= 1'b1;
          rdata_reg              <= '0;
        end
        state_reg <= ST_DONE;
      end
    end
  end

  assign usr_rdata     = rdata_reg;
  assign usr_rvalid    = rvalid_reg;
  assign usr_wdone     = wdone_reg;
  assign usr_err       = err_reg;
  assign m_axi_awaddr  = awaddr_reg;
  assign m_axi_awprot  = AXPROT;
  assign m_axi_awcache = AXCACHE;
  assign m_axi_awvalid = awvalid_reg;
  assign m_axi_wdata   = wdata_reg;
  assign m_axi_wstrb   = '1;
  assign m_axi_wvalid  = wvalid_reg;
  assign m_axi_bready  = bready_reg;
  assign m_axi_araddr  = araddr_reg;
  assign m_axi_arprot  = AXPROT;
  assign m_axi_arcache = AXCACHE;
  assign m_axi_arvalid = arvalid_reg;
  assign m_axi_rready  = rready_reg;

endmodule
